// File: rtl/mem_store_generator_if.sv
// Store-traffic bus: launch/stall controls in, data-memory write triple and status out.
// Latency: none; this file only groups the wires.
// Backpressure: stall from the sink holds the presented store until it is released.
interface mem_store_generator_if;
  logic        start;
  logic        stall;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        busy;
  logic        done;
  logic [7:0]  count;

  // Generator side: drives the store and status, samples launch and stall
  modport master (
    input  start,
    input  stall,
    output memwrite,
    output dataadr,
    output writedata,
    output busy,
    output done,
    output count
  );

  // Sink / controller side
  modport slave (
    output start,
    output stall,
    input  memwrite,
    input  dataadr,
    input  writedata,
    input  busy,
    input  done,
    input  count
  );
endinterface

// File: rtl/mem_store_generator.sv
// Store-burst initiator standing in for the core on the dmem write port (optional macro MEMGEN_LFSR_EN).
// Latency: first memwrite one cycle after start is sampled; GAP_CYCLES idle cycles between stores.
// Backpressure: stall holds memwrite/dataadr/writedata and freezes count until the store is accepted.
module mem_store_generator #(
  parameter int unsigned N_WRITES   = 8,
  parameter logic [31:0] BASE_ADDR  = 32'd80,
  parameter logic [31:0] STRIDE     = 32'd4,
  parameter int unsigned GAP_CYCLES = 1,
  parameter logic [31:0] DATA_INIT  = 32'h07001111
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  mem_store_generator_if.master  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [7:0] LP_N   = 8'(N_WRITES);
  localparam logic [3:0] LP_GAP = 4'(GAP_CYCLES);

`ifdef MEMGEN_LFSR_EN
  // Galois form, taps 32,22,2,1; an all-zero seed would lock the LFSR, so it is replaced by 1
  localparam logic [31:0] LFSR_MASK = 32'h80200003;
  localparam logic [31:0] SEED      = (DATA_INIT == 32'd0) ? 32'd1 : DATA_INIT;
`else
  localparam logic [31:0] SEED      = DATA_INIT;
`endif

  logic [1:0]  r_state;
  logic        r_memwrite;
  logic [31:0] r_dataadr;
  logic [31:0] r_writedata;
  logic        r_busy;
  logic        r_done;
  logic [7:0]  r_count;
  logic [3:0]  r_gap_cnt;

  logic [1:0]  w_state_nxt;
  logic        w_memwrite_nxt;
  logic [31:0] w_dataadr_nxt;
  logic [31:0] w_writedata_nxt;
  logic        w_busy_nxt;
  logic        w_done_nxt;
  logic [7:0]  w_count_nxt;
  logic [3:0]  w_gap_cnt_nxt;

  logic        w_accept;
  logic [7:0]  w_count_inc;
  logic        w_last;
  logic [31:0] w_next_adr;
  logic [31:0] w_next_dat;

  // A store is taken by the sink only while presented and not stalled
  assign w_accept    = (r_state == S_WRITE) && r_memwrite && !bus.stall;
  assign w_count_inc = r_count + 8'd1;
  assign w_last      = (w_count_inc == LP_N);
  assign w_next_adr  = r_dataadr + STRIDE;

`ifdef MEMGEN_LFSR_EN
  assign w_next_dat  = {1'b0, r_writedata[31:1]} ^ (r_writedata[0] ? LFSR_MASK : 32'd0);
`else
  assign w_next_dat  = r_writedata + 32'd1;
`endif

  // Next-state and next-output decode; the registered copy of the store always moves together
  always_comb begin
    w_state_nxt     = r_state;
    w_memwrite_nxt  = r_memwrite;
    w_dataadr_nxt   = r_dataadr;
    w_writedata_nxt = r_writedata;
    w_busy_nxt      = r_busy;
    w_done_nxt      = r_done;
    w_count_nxt     = r_count;
    w_gap_cnt_nxt   = r_gap_cnt;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_state_nxt     = S_WRITE;
          w_memwrite_nxt  = 1'b1;
          w_dataadr_nxt   = BASE_ADDR;
          w_writedata_nxt = SEED;
          w_busy_nxt      = 1'b1;
          w_done_nxt      = 1'b0;
          w_count_nxt     = 8'd0;
          w_gap_cnt_nxt   = 4'd0;
        end
      end

      S_WRITE: begin
        // start is deliberately not looked at here, including on the final acceptance
        if (w_accept) begin
          w_count_nxt = w_count_inc;
          if (w_last) begin
            w_state_nxt    = S_DONE;
            w_memwrite_nxt = 1'b0;
            w_busy_nxt     = 1'b0;
            w_done_nxt     = 1'b1;
          end else if (LP_GAP == 4'd0) begin
            w_dataadr_nxt   = w_next_adr;
            w_writedata_nxt = w_next_dat;
          end else begin
            // Address/data keep the accepted store's values through the gap
            w_state_nxt    = S_GAP;
            w_memwrite_nxt = 1'b0;
            w_gap_cnt_nxt  = LP_GAP - 4'd1;
          end
        end
      end

      S_GAP: begin
        if (r_gap_cnt == 4'd0) begin
          w_state_nxt     = S_WRITE;
          w_memwrite_nxt  = 1'b1;
          w_dataadr_nxt   = w_next_adr;
          w_writedata_nxt = w_next_dat;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - 4'd1;
        end
      end

      default: begin
        w_state_nxt    = S_IDLE;
        w_memwrite_nxt = 1'b0;
        w_busy_nxt     = 1'b0;
        w_done_nxt     = 1'b0;
      end
    endcase
  end

  // State and output registers; async reset drops memwrite without waiting for a clock
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_memwrite  <= 1'b0;
      r_dataadr   <= 32'd0;
      r_writedata <= 32'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_count     <= 8'd0;
      r_gap_cnt   <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_memwrite  <= w_memwrite_nxt;
      r_dataadr   <= w_dataadr_nxt;
      r_writedata <= w_writedata_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_count     <= w_count_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
    end
  end

  assign bus.memwrite  = r_memwrite;
  assign bus.dataadr   = r_dataadr;
  assign bus.writedata = r_writedata;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.count     = r_count;

endmodule

// File: tb/tb_mem_store_generator.sv
// Bench for mem_store_generator: three parameterisations (default, back-to-back, wrapping base).
// Table rows are built from the store-list rules; random phase uses an index-based reference model.
// Inputs driven 1ns after the rising edge, outputs sampled at the same point.
module tb_mem_store_generator;

  typedef struct {
    int          sel;
    logic        start;
    logic        stall;
    logic        mw;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        busy;
    logic        done;
    logic [7:0]  cnt;
  } vec_t;

  localparam logic [31:0] INIT = 32'h07001111;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_store_generator_if if0();
  mem_store_generator_if if1();
  mem_store_generator_if if2();

  mem_store_generator u0 (.i_clk(clk), .i_rst(rst), .bus(if0.master));
  mem_store_generator #(.N_WRITES(3), .GAP_CYCLES(0)) u1 (.i_clk(clk), .i_rst(rst), .bus(if1.master));
  mem_store_generator #(.N_WRITES(4), .BASE_ADDR(32'hFFFFFFF8)) u2 (.i_clk(clk), .i_rst(rst), .bus(if2.master));

  logic        start_a [3];
  logic        stall_a [3];
  logic        mw_a    [3];
  logic [31:0] adr_a   [3];
  logic [31:0] dat_a   [3];
  logic        busy_a  [3];
  logic        done_a  [3];
  logic [7:0]  cnt_a   [3];

  assign if0.start = start_a[0];  assign if0.stall = stall_a[0];
  assign if1.start = start_a[1];  assign if1.stall = stall_a[1];
  assign if2.start = start_a[2];  assign if2.stall = stall_a[2];

  assign mw_a[0] = if0.memwrite; assign adr_a[0] = if0.dataadr; assign dat_a[0] = if0.writedata;
  assign mw_a[1] = if1.memwrite; assign adr_a[1] = if1.dataadr; assign dat_a[1] = if1.writedata;
  assign mw_a[2] = if2.memwrite; assign adr_a[2] = if2.dataadr; assign dat_a[2] = if2.writedata;
  assign busy_a[0] = if0.busy; assign done_a[0] = if0.done; assign cnt_a[0] = if0.count;
  assign busy_a[1] = if1.busy; assign done_a[1] = if1.done; assign cnt_a[1] = if1.count;
  assign busy_a[2] = if2.busy; assign done_a[2] = if2.done; assign cnt_a[2] = if2.count;

  int   nvec = 0;
  int   nmis = 0;
  vec_t vq[$];

  function automatic int n_of(input int sel);
    case (sel)
      1:       return 3;
      2:       return 4;
      default: return 8;
    endcase
  endfunction

  function automatic int gap_of(input int sel);
    return (sel == 1) ? 0 : 1;
  endfunction

  function automatic logic [31:0] addr_of(input int sel, input int k);
    logic [31:0] base;
    base = (sel == 2) ? 32'hFFFFFFF8 : 32'd80;
    return base + 32'(k) * 32'd4;
  endfunction

  function automatic logic [31:0] data_of(input int k);
    logic [31:0] s;
`ifdef MEMGEN_LFSR_EN
    s = (INIT == 32'd0) ? 32'd1 : INIT;
    for (int i = 0; i < k; i++) s = {1'b0, s[31:1]} ^ (s[0] ? 32'h80200003 : 32'd0);
`else
    s = INIT + 32'(k);
`endif
    return s;
  endfunction

  function automatic void push(input int sel, input logic st, input logic sl, input logic mw,
                               input logic [31:0] adr, input logic [31:0] dat,
                               input logic busy, input logic done, input int cnt);
    vec_t v;
    v.sel = sel; v.start = st; v.stall = sl; v.mw = mw; v.adr = adr; v.dat = dat;
    v.busy = busy; v.done = done; v.cnt = 8'(cnt);
    vq.push_back(v);
  endfunction

  // Stall-free burst: store k at BASE+4k, GAP idle cycles after each non-final store
  function automatic void build_burst(input int sel);
    int n;
    n = n_of(sel);
    push(sel, 1'b1, 1'b0, 1'b1, addr_of(sel, 0), data_of(0), 1'b1, 1'b0, 0);
    for (int k = 0; k < n; k++) begin
      if (k == n - 1) begin
        push(sel, 1'b0, 1'b0, 1'b0, addr_of(sel, k), data_of(k), 1'b0, 1'b1, n);
      end else begin
        for (int g = 0; g < gap_of(sel); g++)
          push(sel, 1'b0, 1'b0, 1'b0, addr_of(sel, k), data_of(k), 1'b1, 1'b0, k + 1);
        push(sel, 1'b0, 1'b0, 1'b1, addr_of(sel, k + 1), data_of(k + 1), 1'b1, 1'b0, k + 1);
      end
    end
    push(sel, 1'b0, 1'b0, 1'b0, addr_of(sel, n - 1), data_of(n - 1), 1'b0, 1'b1, n);
  endfunction

  task automatic check(input int sel, input vec_t e, input string name);
    logic ok;
    nvec++;
    ok = (mw_a[sel] === e.mw) && (adr_a[sel] === e.adr) && (dat_a[sel] === e.dat) &&
         (busy_a[sel] === e.busy) && (done_a[sel] === e.done) && (cnt_a[sel] === e.cnt);
    if (!ok) begin
      nmis++;
      $display("FAIL %s dut%0d: got mw=%0b adr=%h dat=%h busy=%0b done=%0b cnt=%0d, want mw=%0b adr=%h dat=%h busy=%0b done=%0b cnt=%0d",
               name, sel, mw_a[sel], adr_a[sel], dat_a[sel], busy_a[sel], done_a[sel], cnt_a[sel],
               e.mw, e.adr, e.dat, e.busy, e.done, e.cnt);
    end
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < vq.size(); i++) begin
      start_a[vq[i].sel] = vq[i].start;
      stall_a[vq[i].sel] = vq[i].stall;
      @(posedge clk);
      #1;
      start_a[vq[i].sel] = 1'b0;
      stall_a[vq[i].sel] = 1'b0;
      check(vq[i].sel, vq[i], $sformatf("%s[%0d]", name, i));
    end
    vq.delete();
  endtask

  function automatic vec_t zero_vec();
    vec_t z;
    z.sel = 0; z.start = 1'b0; z.stall = 1'b0; z.mw = 1'b0; z.adr = 32'd0; z.dat = 32'd0;
    z.busy = 1'b0; z.done = 1'b0; z.cnt = 8'd0;
    return z;
  endfunction

  // Reference: what the next edge does to the expected outputs, in terms of store index
  task automatic model_step(input int sel, input logic st, input logic sl,
                            inout vec_t e, inout int wait_n);
    if (!e.busy) begin
      if (st) begin
        e.mw = 1'b1; e.adr = addr_of(sel, 0); e.dat = data_of(0);
        e.busy = 1'b1; e.done = 1'b0; e.cnt = 8'd0;
      end
    end else if (e.mw) begin
      if (!sl) begin
        e.cnt = e.cnt + 8'd1;
        if (int'(e.cnt) == n_of(sel)) begin
          e.mw = 1'b0; e.busy = 1'b0; e.done = 1'b1;
        end else if (gap_of(sel) == 0) begin
          e.adr = addr_of(sel, int'(e.cnt)); e.dat = data_of(int'(e.cnt));
        end else begin
          e.mw = 1'b0; wait_n = gap_of(sel);
        end
      end
    end else begin
      wait_n = wait_n - 1;
      if (wait_n == 0) begin
        e.mw = 1'b1; e.adr = addr_of(sel, int'(e.cnt)); e.dat = data_of(int'(e.cnt));
      end
    end
  endtask

  initial begin
    vec_t e;
    int   wait_n;
    logic st;
    logic sl;

    for (int i = 0; i < 3; i++) begin start_a[i] = 1'b0; stall_a[i] = 1'b0; end
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) check(i, zero_vec(), "reset_state");
    @(negedge clk);
    rst = 1'b0;

    build_burst(0);
    run_table("default_burst");

    build_burst(1);
    vq[vq.size() - 2].start = 1'b1;   // start on final acceptance must be ignored
    run_table("gap0_burst");

    build_burst(2);
    run_table("wrap_burst");

    // Stall of 4 cycles on store 2, then stop mid-gap after store 3
    push(0, 1'b1, 1'b0, 1'b1, addr_of(0, 0), data_of(0), 1'b1, 1'b0, 0);
    push(0, 1'b0, 1'b0, 1'b0, addr_of(0, 0), data_of(0), 1'b1, 1'b0, 1);
    push(0, 1'b0, 1'b0, 1'b1, addr_of(0, 1), data_of(1), 1'b1, 1'b0, 1);
    push(0, 1'b0, 1'b0, 1'b0, addr_of(0, 1), data_of(1), 1'b1, 1'b0, 2);
    push(0, 1'b0, 1'b0, 1'b1, addr_of(0, 2), data_of(2), 1'b1, 1'b0, 2);
    for (int i = 0; i < 4; i++)
      push(0, 1'b0, 1'b1, 1'b1, addr_of(0, 2), data_of(2), 1'b1, 1'b0, 2);
    push(0, 1'b0, 1'b0, 1'b0, addr_of(0, 2), data_of(2), 1'b1, 1'b0, 3);
    push(0, 1'b0, 1'b0, 1'b1, addr_of(0, 3), data_of(3), 1'b1, 1'b0, 3);
    push(0, 1'b0, 1'b0, 1'b0, addr_of(0, 3), data_of(3), 1'b1, 1'b0, 4);
    run_table("stall_store2");

    rst = 1'b1;
    #1;
    check(0, zero_vec(), "reset_mid_gap");
    @(negedge clk);
    rst = 1'b0;

    build_burst(0);
    run_table("restart_after_reset");

    // Starts while busy are ignored; the start in DONE replays the identical burst
    build_burst(0);
    vq[2].start = 1'b1;
    vq[3].start = 1'b1;
    vq[vq.size() - 2].start = 1'b1;
    build_burst(0);
    run_table("start_busy_then_done");

    push(1, 1'b1, 1'b0, 1'b1, addr_of(1, 0), data_of(0), 1'b1, 1'b0, 0);
    run_table("pre_reset_write");
    rst = 1'b1;
    #1;
    check(1, zero_vec(), "reset_in_write");
    @(negedge clk);
    rst = 1'b0;

    for (int sel = 0; sel < 3; sel++) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      e = zero_vec();
      wait_n = 0;
      for (int c = 0; c < 700; c++) begin
        st = ($urandom_range(0, 9) == 0);
        sl = ($urandom_range(0, 99) < 30);
        model_step(sel, st, sl, e, wait_n);
        start_a[sel] = st;
        stall_a[sel] = sl;
        @(posedge clk);
        #1;
        start_a[sel] = 1'b0;
        stall_a[sel] = 1'b0;
        check(sel, e, $sformatf("random_c%0d", c));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
